// File: rtl/gzip_out_framer_if.sv
// rtl/gzip_out_framer_if.sv - framed AXI-Stream output bus of gzip_out_framer
interface gzip_out_framer_if;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        output m_axis_tuser,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        input  m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/gzip_out_framer.sv
// rtl/gzip_out_framer.sv - frames gzip output words onto AXI-Stream (option: GZIP_OUT_FRAMER_BYTE_SWAP_EN)
module gzip_out_framer #(
    parameter int FRAME_LEN_WIDTH = 16,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                       core_clock,
    input  logic                       bus_reset,
    input  logic                       fifo_empty,
    output logic                       fifo_rden,
    input  logic [31:0]                fifo_dout,
    input  logic                       gzip_done,
    input  logic [FRAME_LEN_WIDTH-1:0] frame_words,
    gzip_out_framer_if.master          m_axis,
    output logic [STAT_WIDTH-1:0]      words_out,
    output logic [STAT_WIDTH-1:0]      frames_out,
    output logic                       stream_end
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t                     state_q;
    logic [31:0]                b0_q, b1_q, b0_d, b1_d;
    logic [1:0]                 count_q, count_d;
    logic                       rd_q;
    logic [FRAME_LEN_WIDTH-1:0] cnt_q, len_q;
    logic [STAT_WIDTH-1:0]      words_q, frames_q;
    logic                       stream_end_q;

    logic [31:0] din_w;
    logic [1:0]  free_w;
    logic        final_w, valid_w, last_w, user_w, pop_w, push_w, boundary_w;

    // Output release decision, read throttling and the 2-entry buffer next state.
    // b0 is the head word presented on the bus; the newest word is never shown
    // until either a successor is arriving or the stream is confirmed finished.
    always_comb begin
`ifdef GZIP_OUT_FRAMER_BYTE_SWAP_EN
        din_w = {fifo_dout[7:0], fifo_dout[15:8], fifo_dout[23:16], fifo_dout[31:24]};
`else
        din_w = fifo_dout;
`endif
        push_w     = rd_q;
        final_w    = (state_q == FLUSH) && gzip_done && fifo_empty && !rd_q && (count_q == 2'd1);
        valid_w    = (count_q == 2'd2) || ((count_q == 2'd1) && (rd_q || final_w));
        boundary_w = (len_q != '0) && (cnt_q == len_q - FRAME_LEN_WIDTH'(1));
        last_w     = valid_w && (boundary_w || final_w);
        user_w     = valid_w && final_w;
        pop_w      = valid_w && m_axis.m_axis_tready;
        // A slot vacated by this cycle's handshake counts, which keeps 1 word/cycle.
        free_w     = 2'd2 - count_q + {1'b0, pop_w};
        fifo_rden  = !bus_reset && !fifo_empty && (free_w > {1'b0, rd_q});

        count_d = count_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        case ({push_w, pop_w})
            2'b10: begin
                if (count_q == 2'd0) b0_d = din_w;
                else                 b1_d = din_w;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                b0_d    = b1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    b0_d = din_w;
                end else begin
                    b0_d = b1_q;
                    b1_d = din_w;
                end
            end
            default: ;
        endcase
    end

    // Buffer storage and the one-deep read-in-flight flag.
    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            b0_q    <= '0;
            b1_q    <= '0;
            count_q <= '0;
            rd_q    <= 1'b0;
        end else begin
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            count_q <= count_d;
            rd_q    <= fifo_rden;
        end
    end

    // Per-frame word counter with frame length frozen once a frame's first word is shown.
    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            cnt_q        <= '0;
            len_q        <= '0;
            words_q      <= '0;
            frames_q     <= '0;
            stream_end_q <= 1'b0;
        end else begin
            stream_end_q <= pop_w && user_w;
            if (pop_w) begin
                words_q <= words_q + STAT_WIDTH'(1);
                if (last_w) begin
                    frames_q <= frames_q + STAT_WIDTH'(1);
                    cnt_q    <= '0;
                    len_q    <= frame_words;
                end else begin
                    cnt_q <= cnt_q + FRAME_LEN_WIDTH'(1);
                end
            end else if ((cnt_q == '0) && !valid_w) begin
                len_q <= frame_words;
            end
        end
    end

    // Stream lifecycle; final release is only allowed while flushing.
    always_ff @(posedge core_clock or posedge bus_reset) begin
        if (bus_reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (push_w) state_q <= STREAM;
                STREAM:  if (gzip_done) state_q <= FLUSH;
                FLUSH:   if (pop_w && user_w) state_q <= DONE;
                DONE:    if (!gzip_done) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis.m_axis_tdata  = b0_q;
    assign m_axis.m_axis_tvalid = valid_w;
    assign m_axis.m_axis_tlast  = last_w;
    assign m_axis.m_axis_tuser  = user_w;
    assign words_out            = words_q;
    assign frames_out           = frames_q;
    assign stream_end           = stream_end_q;

endmodule

// File: tb/tb_gzip_out_framer.sv
// tb/tb_gzip_out_framer.sv - scoreboard bench for gzip_out_framer
module tb_gzip_out_framer;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [31:0] fifo_dout = '0;
    logic        gzip_done = 1'b0;
    logic [15:0] frame_words = '0;
    logic [31:0] words_out, frames_out;
    logic        stream_end;

    gzip_out_framer_if axis ();

    gzip_out_framer dut (
        .core_clock (clk),
        .bus_reset  (rst),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_dout  (fifo_dout),
        .gzip_done  (gzip_done),
        .frame_words(frame_words),
        .m_axis     (axis),
        .words_out  (words_out),
        .frames_out (frames_out),
        .stream_end (stream_end)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    int          wr_idx = 0;
    int          rd_idx = 0;
    assign fifo_empty = (wr_idx == rd_idx);

    always @(posedge clk) begin
        if (fifo_rden && (rd_idx != wr_idx)) begin
            fifo_dout <= mem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          exp_words = 0;
    int          exp_frames = 0;
    int          se_cnt = 0;
    bit          rnd = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l, prev_u;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] w);
`ifdef GZIP_OUT_FRAMER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        axis.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        check("rden_while_empty", {31'b0, fifo_rden & fifo_empty}, 32'd0);
        if (prev_stall) begin
            check("hold_valid", {31'b0, axis.m_axis_tvalid}, 32'd1);
            check("hold_data", axis.m_axis_tdata, prev_d);
            check("hold_last", {31'b0, axis.m_axis_tlast}, {31'b0, prev_l});
            check("hold_user", {31'b0, axis.m_axis_tuser}, {31'b0, prev_u});
        end
        if (axis.m_axis_tvalid && axis.m_axis_tready) begin
            check("beat_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("tdata", axis.m_axis_tdata, e.d);
                check("tlast", {31'b0, axis.m_axis_tlast}, {31'b0, e.l});
                check("tuser", {31'b0, axis.m_axis_tuser}, {31'b0, e.u});
                exp_words++;
                if (e.l) exp_frames++;
            end
        end
        if (stream_end) se_cnt++;
        prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
        prev_d = axis.m_axis_tdata;
        prev_l = axis.m_axis_tlast;
        prev_u = axis.m_axis_tuser;
    endtask

    task automatic push_word(input logic [31:0] w, input logic l, input logic u, input bit expect_it);
        exp_t e;
        mem[wr_idx] = w;
        wr_idx++;
        if (expect_it) begin
            e.d = exp_data(w);
            e.l = l;
            e.u = u;
            sb.push_back(e);
        end
    endtask

    task automatic run_stream(input int n, input logic [31:0] base, input int fw, input bit random_rdy);
        int se_before;
        frame_words = 16'(fw);
        rnd = random_rdy;
        tick();
        for (int i = 0; i < n; i++)
            push_word(base + 32'(i), ((fw != 0) && ((i % fw) == fw - 1)) || (i == n - 1), i == n - 1, 1'b1);
        for (int k = 0; k < 4000 && !(fifo_empty && sb.size() <= 1); k++) tick();
        tick();
        tick();
        gzip_done = 1'b1;
        se_before = se_cnt;
        for (int k = 0; k < 4000 && sb.size() != 0; k++) tick();
        check("drain_timeout", sb.size(), 32'd0);
        repeat (3) tick();
        check("stream_end_pulses", se_cnt - se_before, 32'd1);
        check("words_out", words_out, exp_words);
        check("frames_out", frames_out, exp_frames);
        gzip_done = 1'b0;
        rnd = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        axis.m_axis_tready = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", {31'b0, axis.m_axis_tvalid}, 32'd0);
        check("rst_rden", {31'b0, fifo_rden}, 32'd0);
        check("rst_words", words_out, 32'd0);
        check("rst_frames", frames_out, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // 10 words in frames of 4
        run_stream(10, 32'h1, 4, 1'b0);
        check("t1_words", words_out, 32'd10);
        check("t1_frames", frames_out, 32'd3);

        // unlimited frame
        run_stream(5, 32'h20, 0, 1'b0);
        check("t2_frames", frames_out, 32'd4);

        // boundary coincides with the final word
        run_stream(6, 32'h40, 3, 1'b0);
        check("t3_frames", frames_out, 32'd6);

        // gzip_done with no data produced
        gzip_done = 1'b1;
        repeat (10) tick();
        check("nodata_tvalid", {31'b0, axis.m_axis_tvalid}, 32'd0);
        check("nodata_words", words_out, 32'd21);
        check("nodata_pulses", se_cnt, 32'd3);
        gzip_done = 1'b0;
        repeat (3) tick();

        // random backpressure
        run_stream(200, 32'h1000, 7, 1'b1);
        check("rand_words", words_out, 32'd221);

        // byte order
        run_stream(1, 32'h11223344, 0, 1'b0);

        // reset mid-frame after 2 of 4 words
        frame_words = 16'd4;
        tick();
        push_word(32'hA1, 1'b0, 1'b0, 1'b1);
        push_word(32'hA2, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
        check("pre_reset_drain", sb.size(), 32'd0);
        repeat (3) tick();
        check("pre_reset_held", {31'b0, axis.m_axis_tvalid}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", {31'b0, axis.m_axis_tvalid}, 32'd0);
        check("mid_rst_tlast", {31'b0, axis.m_axis_tlast}, 32'd0);
        check("mid_rst_tuser", {31'b0, axis.m_axis_tuser}, 32'd0);
        check("mid_rst_tdata", axis.m_axis_tdata, 32'd0);
        check("mid_rst_rden", {31'b0, fifo_rden}, 32'd0);
        check("mid_rst_words", words_out, 32'd0);
        check("mid_rst_frames", frames_out, 32'd0);
        check("mid_rst_se", {31'b0, stream_end}, 32'd0);
        repeat (2) tick();
        prev_stall = 1'b0;
        exp_words = 0;
        exp_frames = 0;
        rst = 1'b0;
        repeat (2) tick();
        run_stream(5, 32'h200, 4, 1'b0);
        check("post_rst_words", words_out, 32'd5);
        check("post_rst_frames", frames_out, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
